stencil_ai_loader: RTL and testbench
====================================

# stencil_ai_loader

Double-buffered input stage placed directly upstream of `stencil_1d_hir` / `stencil_1d_hls`. It accepts a valid/ready word stream, packs each group of SIZE words into one of two internal banks, and serves the stencil kernel's `Ai_p0` read port from the completed bank. It issues the kernel start pulse `t` per frame. The next frame is filled while the kernel reads the current one; this replaces the `$readmemb`-preloaded array plus `memref_rd` used in standalone benches.

## Interface
- `WIDTH`, 32: data word width.
- `SIZE`, 64: words per frame (bank depth); must be a power of two, ≥ 2.
- `ADDR_W`, 6: address width, equal to log2(SIZE).

- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset; one clock domain only.
- `s_valid` in 1: stream word valid.
- `s_data` in WIDTH: stream word.
- `s_ready` out 1: loader can accept a word.
- `Ai_p0_addr_en` in 1: kernel address strobe; accepted, otherwise ignored.
- `Ai_p0_addr_data` in ADDR_W: kernel read address.
- `Ai_p0_rd_en` in 1: kernel read enable.
- `Ai_p0_rd_data` out WIDTH: read data, registered.
- `t` out 1: kernel start pulse, one cycle.
- `done` in 1: kernel-finished pulse; releases the read bank.
- `busy` out 1: the kernel currently owns the read bank.
- `frame_cnt` out 16: frames handed to the kernel; wraps modulo 2^16.

## Operation
- Storage: two banks, each SIZE×WIDTH. Bank contents are not reset.
- Registers:
  - `wr_bank`, the bank being filled; reset 0.
  - `rd_bank`, the bank served to the kernel; reset 1.
  - `wcnt`, ADDR_W+1 bits; reset 0.
  - `busy`; reset 0.
- FSM states: FILL (reset state) and HANDOFF.
- FILL:
  - `s_ready`=1.
  - On `s_valid`&&`s_ready`: write `bank[wr_bank][wcnt]` = `s_data`, then `wcnt`++.
  - Accepting the word at `wcnt`==SIZE-1 moves to HANDOFF and sets `wcnt` to 0.
- HANDOFF:
  - `s_ready`=0.
  - The handoff condition is (`!busy` || `done`).
  - If it holds, on that edge: `rd_bank` ← `wr_bank`, `wr_bank` ← ~`wr_bank`, `busy` ← 1, `t` ← 1 for exactly one cycle, `frame_cnt`++, and the state returns to FILL.
  - Otherwise stay in HANDOFF. The stream is stalled and no data is lost.
- `done` outside a handoff edge clears `busy` on that edge. A `done` received while `busy`=0 is ignored.
- Read port:
  - On `Ai_p0_rd_en`=1: `Ai_p0_rd_data` ← `bank[rd_bank][Ai_p0_addr_data]` at the next edge.
  - Otherwise `Ai_p0_rd_data` holds its value.
  - Reads are not gated by `busy`. Before the first handoff they return undefined bank contents.
- The write bank and the read bank are always distinct, so there is no read/write collision.
- Reset mid-operation (`rst` low at any time):
  - All registers return to their reset values immediately, FSM goes to FILL, and a partial frame is discarded.
  - Bank contents are retained but treated as invalid.

## Timing
- Reset values: `s_ready`=1 (FILL), `Ai_p0_rd_data`=0, `t`=0, `busy`=0, `frame_cnt`=0.
- `s_ready` is decoded from registered state only; there is no combinational path from `s_valid`.
- Throughput: one word per cycle in FILL.
- Frame latency, with the kernel idle:
  - The last word is accepted at edge E0.
  - HANDOFF commits at E1.
  - `t` is high during the cycle after E1.
  - Minimum frame period is SIZE+1 cycles.
- Read latency is 1 cycle: address presented in cycle N gives data valid after edge N+1. A kernel read issued in the same cycle as `t` sees the new `rd_bank`.
- Back-to-back `done` and handoff on the same edge produces a new `t` with no idle cycle; `busy` stays 1.
- `rst` deassertion is synchronised by the bench or top level. The first accept may occur on the first edge after release.

## Test plan
- Reset/idle:
  - Stimulus: hold `rst`=0 for 3 cycles, then release with `s_valid`=0.
  - Required: `s_ready`=1, `t`=0, `busy`=0, `frame_cnt`=0, `Ai_p0_rd_data`=0.
- Single frame:
  - Stimulus: stream words 0..63 (value = index) continuously, kernel idle.
  - Required: `t` pulses exactly once, 2 cycles after the 64th accept.
  - Required: reading addresses 0, 17 and 63 returns 0, 17 and 63 one cycle after each request.
- Backpressure:
  - Stimulus: stream frame B (value = 100+index) while frame A is `busy`, with no `done`.
  - Required: after 64 accepts `s_ready`=0 and stays 0.
  - Required: reads still return frame A values.
  - Stimulus: assert `done` for 1 cycle.
  - Required: `t` fires in the next cycle and reads now return 100+index.
- Simultaneous `done` + HANDOFF:
  - Stimulus: `done` arrives on the same edge that HANDOFF commits.
  - Required: `busy` stays 1, `frame_cnt` increments by 1, and no lost or extra `t` pulse.
- Reset mid-frame:
  - Stimulus: accept 30 words, pulse `rst` low, then stream 64 fresh words (value = 200+index).
  - Required: `t` fires only after the 64th fresh word, `frame_cnt`=1, and address 0 reads 200.
- Stalled stream:
  - Stimulus: drive `s_valid` in a random on/off pattern.
  - Required: exactly 64 accepts per `t`.
  - Required: data order is preserved; address k holds the k-th accepted word.

Source files
------------

// File: rtl/stencil_ai_loader.sv
`default_nettype none
// ============================================================================
// Module  : stencil_ai_loader
// Brief   : Double-buffered stream-to-bank loader serving the stencil kernel's
//           Ai_p0 read port and issuing one start pulse per frame.
// Rev     : 1.0
// ============================================================================
module stencil_ai_loader #(
    parameter int WIDTH  = 32,
    parameter int SIZE   = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [WIDTH-1:0]  s_data,
    output logic              s_ready,
    input  logic              Ai_p0_addr_en,
    input  logic [ADDR_W-1:0] Ai_p0_addr_data,
    input  logic              Ai_p0_rd_en,
    output logic [WIDTH-1:0]  Ai_p0_rd_data,
    output logic              t,
    input  logic              done,
    output logic              busy,
    output logic [15:0]       frame_cnt
);

    localparam logic [ADDR_W:0] c_LAST = (ADDR_W+1)'(SIZE - 1);

    typedef enum logic [0:0] {
        S_FILL    = 1'b0,
        S_HANDOFF = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [ADDR_W:0]   r_wcnt;
    logic              r_busy;
    logic              r_t;
    logic [15:0]       r_frame_cnt;
    logic [WIDTH-1:0]  r_rd_data;

    // Both banks in one array, addressed as {bank, word}.
    logic [WIDTH-1:0]  r_mem [2*SIZE];

    logic              w_fill;
    logic              w_accept;
    logic              w_handoff;
    logic              w_unused;

    assign w_fill    = (r_state == S_FILL);
    assign w_accept  = s_valid && w_fill;
    assign w_handoff = (r_state == S_HANDOFF) && (!r_busy || done);
    assign w_unused  = Ai_p0_addr_en;

    assign s_ready       = w_fill;
    assign t             = r_t;
    assign busy          = r_busy;
    assign frame_cnt     = r_frame_cnt;
    assign Ai_p0_rd_data = r_rd_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_FILL;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b1;
            r_wcnt      <= '0;
            r_busy      <= 1'b0;
            r_t         <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_t <= 1'b0;
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        if (r_wcnt == c_LAST) begin
                            r_wcnt  <= '0;
                            r_state <= S_HANDOFF;
                        end else begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                    end
                end
                S_HANDOFF: begin
                    if (w_handoff) begin
                        r_rd_bank   <= r_wr_bank;
                        r_wr_bank   <= ~r_wr_bank;
                        r_t         <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_state     <= S_FILL;
                    end
                end
                default: r_state <= S_FILL;
            endcase

            // A handoff re-arms busy even when done lands on the same edge.
            if (w_handoff) begin
                r_busy <= 1'b1;
            end else if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[{r_wr_bank, r_wcnt[ADDR_W-1:0]}] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_data <= '0;
        end else if (Ai_p0_rd_en) begin
            r_rd_data <= r_mem[{r_rd_bank, Ai_p0_addr_data}];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stencil_ai_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_stencil_ai_loader
// Brief   : Self-checking bench; a frame-level model hands each consecutive
//           group of SIZE accepted words to the kernel on every start pulse.
// Rev     : 1.0
// ============================================================================
module tb_stencil_ai_loader;

    localparam int WIDTH  = 32;
    localparam int SIZE   = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic [WIDTH-1:0]  s_data;
    logic              s_ready;
    logic              Ai_p0_addr_en;
    logic [ADDR_W-1:0] Ai_p0_addr_data;
    logic              Ai_p0_rd_en;
    logic [WIDTH-1:0]  Ai_p0_rd_data;
    logic              t;
    logic              done;
    logic              busy;
    logic [15:0]       frame_cnt;

    always #5 clk = ~clk;

    stencil_ai_loader #(
        .WIDTH  (WIDTH),
        .SIZE   (SIZE),
        .ADDR_W (ADDR_W)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .s_valid         (s_valid),
        .s_data          (s_data),
        .s_ready         (s_ready),
        .Ai_p0_addr_en   (Ai_p0_addr_en),
        .Ai_p0_addr_data (Ai_p0_addr_data),
        .Ai_p0_rd_en     (Ai_p0_rd_en),
        .Ai_p0_rd_data   (Ai_p0_rd_data),
        .t               (t),
        .done            (done),
        .busy            (busy),
        .frame_cnt       (frame_cnt)
    );

    int               n_chk = 0;
    int               n_err = 0;
    int               n_t   = 0;
    int               cyc   = 0;
    logic [WIDTH-1:0] pending [$];
    logic [WIDTH-1:0] kern [SIZE];
    logic [15:0]      exp_fc = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: records an accepted word, and on a start pulse moves the
    // oldest SIZE accepted words into the kernel-visible frame.
    task automatic step();
        bit               acc;
        logic [WIDTH-1:0] d;
        acc = s_valid && s_ready && rst;
        d   = s_data;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) pending.push_back(d);
        if (t) begin
            n_t++;
            chk("accepts_per_t", 64'(pending.size()), 64'(SIZE));
            for (int k = 0; k < SIZE; k++) begin
                if (pending.size() > 0) kern[k] = pending.pop_front();
                else                    kern[k] = 'x;
            end
            exp_fc++;
            chk("frame_cnt_at_t", 64'(frame_cnt), 64'(exp_fc));
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input bit gaps);
        int guard;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                s_valid = 1'b0;
                step();
            end
        end
        s_valid = 1'b1;
        s_data  = d;
        guard   = 0;
        while (!s_ready && guard < 200) begin
            step();
            guard++;
        end
        if (guard >= 200) begin
            n_chk++;
            n_err++;
            $error("FAIL send_timeout: observed s_ready %0b expected 1", s_ready);
        end
        step();
    endtask

    task automatic rd(input int a);
        Ai_p0_rd_en     = 1'b1;
        Ai_p0_addr_en   = 1'b1;
        Ai_p0_addr_data = a[ADDR_W-1:0];
        step();
        Ai_p0_rd_en   = 1'b0;
        Ai_p0_addr_en = 1'b0;
        chk($sformatf("rd[%0d]", a), 64'(Ai_p0_rd_data), 64'(kern[a]));
    endtask

    task automatic wait_t(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            step();
            if (t) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int nt0;
        int nrdy;
        logic [15:0] fc0;

        rst             = 1'b0;
        s_valid         = 1'b0;
        s_data          = '0;
        Ai_p0_addr_en   = 1'b0;
        Ai_p0_addr_data = '0;
        Ai_p0_rd_en     = 1'b0;
        done            = 1'b0;

        // Reset / idle
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        chk("rst_t", 64'(t), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_rd_data", 64'(Ai_p0_rd_data), 64'd0);

        // Single frame, continuous stream, kernel idle
        c0 = cyc;
        for (int i = 0; i < SIZE; i++) send(WIDTH'(i), 1'b0);
        s_valid = 1'b0;
        chk("throughput", 64'(cyc - c0), 64'(SIZE));
        chk("t_at_last_accept", 64'(t), 64'd0);
        chk("handoff_s_ready", 64'(s_ready), 64'd0);
        nt0 = n_t;
        step();
        chk("t_after_handoff", 64'(t), 64'd1);
        chk("busy_after_handoff", 64'(busy), 64'd1);
        step();
        chk("t_one_cycle", 64'(t), 64'd0);
        chk("fill_s_ready", 64'(s_ready), 64'd1);
        chk("single_t_count", 64'(n_t - nt0), 64'd1);
        rd(0);
        chk("rd0_const", 64'(Ai_p0_rd_data), 64'd0);
        rd(17);
        chk("rd17_const", 64'(Ai_p0_rd_data), 64'd17);
        rd(63);
        chk("rd63_const", 64'(Ai_p0_rd_data), 64'd63);
        Ai_p0_addr_data = 6'd5;
        step();
        chk("rd_hold", 64'(Ai_p0_rd_data), 64'd63);

        // Backpressure: frame B waits for done
        nt0 = n_t;
        for (int i = 0; i < SIZE; i++) send(WIDTH'(100 + i), 1'b0);
        s_valid = 1'b0;
        nrdy = 0;
        repeat (6) begin
            step();
            if (s_ready) nrdy++;
        end
        chk("bp_s_ready_low", 64'(nrdy), 64'd0);
        chk("bp_no_t", 64'(n_t - nt0), 64'd0);
        rd(5);
        chk("bp_rd5_frameA", 64'(Ai_p0_rd_data), 64'd5);
        rd(40);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("bp_t_after_done", 64'(t), 64'd1);
        chk("bp_busy", 64'(busy), 64'd1);
        rd(0);
        chk("bp_rd0_frameB", 64'(Ai_p0_rd_data), 64'd100);
        rd(63);
        chk("bp_rd63_frameB", 64'(Ai_p0_rd_data), 64'd163);

        // done arriving on the handoff edge
        for (int i = 0; i < SIZE; i++) send($urandom(), 1'b0);
        s_valid = 1'b0;
        done    = 1'b1;
        fc0     = frame_cnt;
        nt0     = n_t;
        step();
        done = 1'b0;
        chk("sim_t", 64'(t), 64'd1);
        chk("sim_busy", 64'(busy), 64'd1);
        chk("sim_frame_cnt", 64'(frame_cnt), 64'(fc0 + 16'd1));
        repeat (3) step();
        chk("sim_t_count", 64'(n_t - nt0), 64'd1);
        rd($urandom_range(0, SIZE - 1));
        rd($urandom_range(0, SIZE - 1));

        // done while filling releases busy; a second done is ignored
        fc0 = frame_cnt;
        done = 1'b1;
        step();
        done = 1'b0;
        chk("done_clears_busy", 64'(busy), 64'd0);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("idle_done_busy", 64'(busy), 64'd0);
        chk("idle_done_t", 64'(t), 64'd0);
        chk("idle_done_fc", 64'(frame_cnt), 64'(fc0));

        // Reset mid-frame discards the partial frame
        for (int i = 0; i < 30; i++) send($urandom(), 1'b0);
        s_valid = 1'b0;
        rst     = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_fc", 64'(frame_cnt), 64'd0);
        chk("mid_rst_rd_data", 64'(Ai_p0_rd_data), 64'd0);
        chk("mid_rst_s_ready", 64'(s_ready), 64'd1);
        pending.delete();
        exp_fc = '0;
        step();
        step();
        rst = 1'b1;
        nt0 = n_t;
        for (int i = 0; i < SIZE; i++) send(WIDTH'(200 + i), 1'b0);
        s_valid = 1'b0;
        chk("mid_rst_no_early_t", 64'(n_t - nt0), 64'd0);
        step();
        chk("mid_rst_t", 64'(t), 64'd1);
        chk("mid_rst_fc_one", 64'(frame_cnt), 64'd1);
        rd(0);
        chk("mid_rst_rd0", 64'(Ai_p0_rd_data), 64'd200);

        // Stalled stream with random gaps and data
        for (int f = 0; f < 3; f++) begin
            done = 1'b1;
            step();
            done = 1'b0;
            for (int i = 0; i < SIZE; i++) send($urandom(), 1'b1);
            s_valid = 1'b0;
            wait_t("stall_t");
            for (int r = 0; r < 6; r++) rd($urandom_range(0, SIZE - 1));
            rd(0);
            rd(SIZE - 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
